chunked_subtractor_seq: RTL and testbench

- Multi-cycle WIDTH-bit two's-complement subtractor that computes D = X - Y.
- Processes CHUNK bits per clock. The ripple path is a chain of 1-bit full-adder cells fed with X, ~Y and carry-in 1; the carry is held in a register between chunks.
- It is the subtract-direction counterpart of the team's combinational ripple adder, and it bounds the carry path to CHUNK cells per cycle.
- Operands come in over a valid/ready request channel; results go out over a valid/ready response channel with borrow, zero and signed-overflow flags.

---
 rtl/chunked_subtractor_seq_pkg.sv | 14 +
 rtl/chunked_subtractor_seq_chunk_ripple_adder.sv | 23 ++
 rtl/chunked_subtractor_seq.sv | 120 ++++++++++++
 tb/tb_chunked_subtractor_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/chunked_subtractor_seq_pkg.sv
// Shared types for the chunked subtractor: FSM state encoding.
package chunked_subtractor_seq_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_DONE = ST_DONE_ENC
    } state_t;

endpackage

// File: rtl/chunked_subtractor_seq_chunk_ripple_adder.sv
// CHUNK-bit ripple-carry adder built from a chain of 1-bit full-adder cells.
module chunk_ripple_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/chunked_subtractor_seq.sv
// Multi-cycle D = X - Y, CHUNK bits per RUN cycle via X + ~Y + 1 with a carry register.
module chunked_subtractor_seq
    import chunked_subtractor_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             zero,
    output logic             ovf
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int OFFW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic [WIDTH-1:0]  x_q;
    logic [WIDTH-1:0]  yn_q;
    logic [WIDTH-1:0]  d_q;
    logic [WIDTH-1:0]  d_d;
    logic              bo_q, zero_q, ovf_q;
    logic              start_ready_q, done_valid_q;

    logic [OFFW-1:0]   off;
    logic [CHUNK-1:0]  sum;
    logic              cout;
    logic              last;

    assign off  = OFFW'(idx_q * CHUNK);
    assign last = (idx_q == IDXW'(N - 1));

    chunk_ripple_adder #(.CHUNK(CHUNK)) u_adder (
        .a    (x_q[off +: CHUNK]),
        .b    (yn_q[off +: CHUNK]),
        .cin  (carry_q),
        .s    (sum),
        .cout (cout)
    );

    // Full difference including the chunk being written this cycle, so flags
    // can be registered on the same edge as the final chunk.
    always_comb begin
        d_d = d_q;
        d_d[off +: CHUNK] = sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            carry_q       <= 1'b0;
            x_q           <= '0;
            yn_q          <= '0;
            d_q           <= '0;
            bo_q          <= 1'b0;
            zero_q        <= 1'b0;
            ovf_q         <= 1'b0;
            start_ready_q <= 1'b1;
            done_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid && start_ready_q) begin
                        x_q           <= X;
                        yn_q          <= ~Y;
                        carry_q       <= 1'b1;
                        idx_q         <= '0;
                        start_ready_q <= 1'b0;
                        state_q       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    d_q     <= d_d;
                    carry_q <= cout;
                    idx_q   <= last ? '0 : idx_q + 1'b1;
                    if (last) begin
                        bo_q         <= ~cout;
                        zero_q       <= (d_d == '0);
                        ovf_q        <= (x_q[WIDTH-1] != ~yn_q[WIDTH-1]) &&
                                        (d_d[WIDTH-1] != x_q[WIDTH-1]);
                        done_valid_q <= 1'b1;
                        state_q      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (done_ready) begin
                        done_valid_q  <= 1'b0;
                        start_ready_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    start_ready_q <= 1'b1;
                    done_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign done_valid  = done_valid_q;
    assign D           = d_q;
    assign Bo          = bo_q;
    assign zero        = zero_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_chunked_subtractor_seq.sv
// Self-checking bench for chunked_subtractor_seq against an arithmetic reference model.
module tb_chunked_subtractor_seq;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] X, Y;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] D;
    logic             Bo, zero, ovf;

    int errors = 0;
    int checks = 0;

    chunked_subtractor_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .X           (X),
        .Y           (Y),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .D           (D),
        .Bo          (Bo),
        .zero        (zero),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         output logic [WIDTH-1:0] d, output logic bo,
                         output logic z, output logic ov);
        longint sr;
        d  = x - y;
        bo = (x < y);
        z  = (d == 0);
        sr = longint'($signed(x)) - longint'($signed(y));
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int hold);
        logic [WIDTH-1:0] ed;
        logic eb, ez, eo;
        int lat;
        int waits;
        model(x, y, ed, eb, ez, eo);
        @(negedge clk);
        waits = 0;
        while (!start_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk("start_ready_before_accept", start_ready, 1'b1);
        start_valid = 1'b1;
        X = x;
        Y = y;
        done_ready = 1'b0;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start_valid = 1'($urandom_range(0, 1));
            X = $urandom;
            Y = $urandom;
            if (!done_valid) chk("start_ready_busy", start_ready, 1'b0);
        end while (!done_valid && lat < 50);
        chk("latency", 64'(lat), 64'(N + 1));
        chk("D", D, ed);
        chk("Bo", Bo, eb);
        chk("zero", zero, ez);
        chk("ovf", ovf, eo);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            start_valid = 1'($urandom_range(0, 1));
            X = $urandom;
            Y = $urandom;
            chk("hold_valid", done_valid, 1'b1);
            chk("hold_ready", start_ready, 1'b0);
            chk("hold_D", {D, Bo, zero, ovf}, {ed, eb, ez, eo});
        end
        start_valid = 1'b0;
        done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_ready = 1'b0;
        chk("release_ready", start_ready, 1'b1);
        chk("release_valid", done_valid, 1'b0);
        chk("idle_hold_D", D, ed);
    endtask

    initial begin
        logic [WIDTH-1:0] rx, ry;
        rst = 1'b1;
        start_valid = 1'b0;
        done_ready = 1'b0;
        X = '0;
        Y = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_start_ready", start_ready, 1'b1);
        chk("rst_done_valid", done_valid, 1'b0);
        chk("rst_D", D, '0);
        chk("rst_flags", {Bo, zero, ovf}, 3'b000);

        do_op(32'd5, 32'd3, 0);
        do_op(32'd0, 32'd1, 1);
        do_op(32'h8000_0000, 32'd1, 0);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 2);
        do_op(32'h1234_5678, 32'h1234_5678, 0);
        do_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 10);

        // Reset during the second RUN cycle must abandon the operation.
        @(negedge clk);
        start_valid = 1'b1;
        X = 32'hFFFF_0000;
        Y = 32'h0000_FFFF;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        chk("run1_ready", start_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", start_ready, 1'b1);
        chk("midrst_valid", done_valid, 1'b0);
        chk("midrst_D", D, '0);
        do_op(32'd100, 32'd58, 0);

        for (int i = 0; i < 20; i++) begin
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 4))
                0: ry = rx;
                1: ry = rx + 32'd1;
                2: rx = {1'b1, 31'($urandom)};
                default: ;
            endcase
            do_op(rx, ry, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
